// File: rtl/anvil_shared_tlb.sv
// Shared second-level TLB behind the L1 I/D TLBs, with a fully-associative entry array and a page-table-walker handoff.
// A request sampled in IDLE gives a hit update or a walker access two cycles later; a losing simultaneous request is dropped.
module anvil_shared_tlb #(
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          enable_translation_i,
  input  logic          en_ld_st_translation_i,
  input  logic [15:0]   asid_i,
  input  logic          itlb_access_i,
  input  logic          itlb_hit_i,
  input  logic [63:0]   itlb_vaddr_i,
  input  logic          dtlb_access_i,
  input  logic          dtlb_hit_i,
  input  logic [63:0]   dtlb_vaddr_i,
  output logic [109:0]  itlb_update_o,
  output logic [109:0]  dtlb_update_o,
  output logic          shared_tlb_access_o,
  output logic          shared_tlb_hit_o,
  output logic          itlb_req_o,
  output logic [63:0]   shared_tlb_vaddr_o,
  output logic          shared_tlb_miss_o,
  input  logic [109:0]  ptw_update_i,
  input  logic          ptw_error_i,
  input  logic          ptw_access_exception_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        valid;
    logic [1:0]  is_page;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [63:0] pte;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_PTW} state_t;

  state_t             state_q, state_d;
  tlb_entry_t         entries_q [DEPTH];
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [63:0]        lat_vaddr_q;
  logic               lat_is_i_q;
  logic [15:0]        lat_asid_q;
  tlb_entry_t         itlb_upd_q, dtlb_upd_q;

  logic               d_req, i_req;
  logic               start_req, lookup_hit, lookup_miss, ptw_fill;
  logic               hit_found, inv_found;
  logic [IDX_W-1:0]   hit_idx, victim_idx;
  tlb_entry_t         ptw_entry;

  assign d_req     = dtlb_access_i & ~dtlb_hit_i & en_ld_st_translation_i;
  assign i_req     = itlb_access_i & ~itlb_hit_i & enable_translation_i;
  assign ptw_entry = ptw_update_i;

  assign itlb_update_o = itlb_upd_q;
  assign dtlb_update_o = dtlb_upd_q;

  // Superpage entries compare only the upper VPN levels; is_page 11 is reserved and never matches.
  function automatic logic entry_hit(input tlb_entry_t e, input logic [26:0] vpn,
                                     input logic [15:0] asid);
    logic asid_ok;
    logic vpn_ok;
    asid_ok = (e.asid == asid) || e.pte[5];
    case (e.is_page)
      2'b00:   vpn_ok = (e.vpn == vpn);
      2'b01:   vpn_ok = (e.vpn[26:9] == vpn[26:9]);
      2'b10:   vpn_ok = (e.vpn[26:18] == vpn[26:18]);
      default: vpn_ok = 1'b0;
    endcase
    return e.valid && asid_ok && vpn_ok;
  endfunction

  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    inv_found  = 1'b0;
    victim_idx = rr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit_found && entry_hit(entries_q[i], lat_vaddr_q[38:12], lat_asid_q)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!inv_found && !entries_q[i].valid) begin
        inv_found  = 1'b1;
        victim_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_req   = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    ptw_fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          start_req = 1'b1;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_found) begin
          lookup_hit = 1'b1;
          state_d    = IDLE;
        end else begin
          lookup_miss = 1'b1;
          state_d     = WAIT_PTW;
        end
      end
      WAIT_PTW: begin
        if (ptw_error_i || ptw_access_exception_i) begin
          state_d = IDLE;
        end else if (ptw_entry.valid) begin
          ptw_fill = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d     = IDLE;
      start_req   = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      ptw_fill    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      rr_ptr_q            <= '0;
      lat_vaddr_q         <= '0;
      lat_is_i_q          <= 1'b0;
      lat_asid_q          <= '0;
      itlb_upd_q          <= '0;
      dtlb_upd_q          <= '0;
      shared_tlb_access_o <= 1'b0;
      shared_tlb_hit_o    <= 1'b0;
      shared_tlb_miss_o   <= 1'b0;
      shared_tlb_vaddr_o  <= '0;
      itlb_req_o          <= 1'b0;
    end else begin
      itlb_upd_q          <= '0;
      dtlb_upd_q          <= '0;
      shared_tlb_access_o <= 1'b0;
      shared_tlb_hit_o    <= 1'b0;
      shared_tlb_miss_o   <= 1'b0;
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
        rr_ptr_q           <= '0;
        shared_tlb_vaddr_o <= '0;
        itlb_req_o         <= 1'b0;
      end else begin
        if (start_req) begin
          lat_vaddr_q <= d_req ? dtlb_vaddr_i : itlb_vaddr_i;
          lat_is_i_q  <= ~d_req;
          lat_asid_q  <= asid_i;
        end
        // Walker-facing address stays up from the lookup result until the FSM is idle again.
        if (state_q == LOOKUP) begin
          shared_tlb_vaddr_o <= lat_vaddr_q;
          itlb_req_o         <= lat_is_i_q;
        end else if (state_q == IDLE) begin
          shared_tlb_vaddr_o <= '0;
          itlb_req_o         <= 1'b0;
        end
        if (lookup_hit) begin
          shared_tlb_access_o <= 1'b1;
          shared_tlb_hit_o    <= 1'b1;
          if (lat_is_i_q) itlb_upd_q <= entries_q[hit_idx];
          else            dtlb_upd_q <= entries_q[hit_idx];
        end
        if (lookup_miss) begin
          shared_tlb_access_o <= 1'b1;
          shared_tlb_miss_o   <= 1'b1;
        end
        if (ptw_fill) begin
          entries_q[victim_idx] <= ptw_entry;
          if (!inv_found) rr_ptr_q <= rr_ptr_q + IDX_W'(1);
          if (lat_is_i_q) itlb_upd_q <= ptw_entry;
          else            dtlb_upd_q <= ptw_entry;
        end
      end
    end
  end

endmodule

// File: doc/anvil_shared_tlb.md
ANVIL_SHARED_TLB -- requirements
Module: anvil_shared_tlb

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of fully-associative entries (power of two, 2..32).
REQ-002 SHALL have ports: clk_i  in  1  clock (all state on rising edge).
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  invalidate all entries, abort request.
REQ-005 enable_translation_i / en_ld_st_translation_i  in  1 each  instruction / load-store translation enable.
REQ-006 asid_i  in  16  current ASID.
REQ-007 itlb_access_i, itlb_hit_i / dtlb_access_i, dtlb_hit_i  in  1 each  L1 TLB lookup and hit.
REQ-008 itlb_vaddr_i / dtlb_vaddr_i  in  64 each  L1 lookup virtual address.
REQ-009 itlb_update_o / dtlb_update_o  out  110 each  {valid[109], is_page[108:107], vpn[106:80], asid[79:64], pte[63:0]}.
REQ-010 shared_tlb_access_o, shared_tlb_hit_o, itlb_req_o  out  1 each  request to page-table walker.
REQ-011 shared_tlb_vaddr_o  out  64  request address to walker.
REQ-012 shared_tlb_miss_o  out  1  performance-counter miss pulse.
REQ-013 ptw_update_i  in  110  walker result, same layout as REQ-009.
REQ-014 ptw_error_i, ptw_access_exception_i  in  1 each  walk terminated without update.

Function
REQ-015 SHALL hold DEPTH entries of {valid, is_page[1:0], vpn[26:0], asid[15:0], pte[63:0]}.
REQ-016 SHALL implement states IDLE, LOOKUP, WAIT_PTW.
REQ-017 Request candidates in IDLE: D = dtlb_access_i & ~dtlb_hit_i & en_ld_st_translation_i; I = itlb_access_i & ~itlb_hit_i & enable_translation_i.
REQ-018 In IDLE with D or I, SHALL latch vaddr, side (D wins when both), asid_i, and go to LOOKUP; loser is not queued.
REQ-019 Entry hit = valid & (asid match | pte[5] global) & vpn match: is_page 00 all 27 bits, 01 vpn[26:9], 10 vpn[26:18]; vpn = vaddr[38:12]. is_page 11 never hits.
REQ-020 LOOKUP hit (lowest-index matching entry): next cycle pulse requester's update_o valid with entry contents, pulse shared_tlb_access_o and shared_tlb_hit_o, return to IDLE.
REQ-021 LOOKUP miss: next cycle pulse shared_tlb_access_o with shared_tlb_hit_o=0 and shared_tlb_miss_o, enter WAIT_PTW.
REQ-022 Request latency: cycle T sampled in IDLE -> update_o or walker access at T+2.
REQ-023 shared_tlb_vaddr_o and itlb_req_o SHALL hold latched value from LOOKUP until return to IDLE; itlb_req_o=1 for instruction side.
REQ-024 In WAIT_PTW, ptw_update_i valid SHALL write entry and pulse requester's update_o with same payload next cycle, state IDLE.
REQ-025 Victim: lowest-index invalid entry; if none, round-robin pointer, incremented (mod DEPTH) only when replacing a valid entry.
REQ-026 ptw_error_i or ptw_access_exception_i in WAIT_PTW: return to IDLE, no write, no update_o.
REQ-027 ptw_update_i valid outside WAIT_PTW SHALL be ignored.
REQ-028 flush_i in any state: clear all valid bits and round-robin pointer, go IDLE next cycle, suppress pending pulses; flush wins over simultaneous update, hit or new request.
REQ-029 All pulse outputs SHALL be exactly one cycle wide; update_o payload fields are don't-care when valid=0 but driven to 0.

Reset
REQ-030 On rst_ni low: state IDLE, all entries invalid, pointer 0, every output 0, independent of clock.
REQ-031 Reset mid-walk SHALL abandon request; a later ptw_update_i is ignored per REQ-027.

Verification
REQ-032 Empty TLB, dtlb miss vaddr 0x0000_0040_1234_5000 at T -> T+2 shared_tlb_access_o=1, hit_o=0, miss_o=1, vaddr_o held; update 4K asid 5 -> dtlb_update_o valid next cycle; repeat -> dtlb_update_o at T+2, no walker access.
REQ-033 itlb and dtlb miss same cycle -> itlb_req_o=0, dtlb serviced; itlb retried later -> itlb_req_o=1.
REQ-034 1G entry vpn 0x4000000, asid 3, G=1; lookup asid 7 vpn 0x4000123 -> hit; G=0 -> miss.
REQ-035 Fill DEPTH+2 distinct pages -> entries 0 then 1 replaced, pointer=2.
REQ-036 flush_i same cycle as ptw_update_i valid -> no update_o, all entries invalid, IDLE.
REQ-037 ptw_error_i in WAIT_PTW -> IDLE, no update_o; rst_ni low mid-walk -> all outputs 0 immediately.
